reset_seq_gen: RTL

Parametrised, synthesizable reset sequencer and the next generation of the design's fixed single-output reset generator. It synchronises the board reset and a PLL lock indication, filters the lock, then releases NUM_CH reset outputs one at a time with a programmable cycle delay between stages. Loss of lock or a soft-reset request re-asserts all outputs and restarts the sequence. It sits at the top of the design and feeds the camera, LCD and datapath reset domains.

---
 rtl/reset_seq_pkg.sv | 20 ++
 rtl/reset_seq_gen_sync_2ff.sv | 18 +
 rtl/reset_seq_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the sequenced reset generator.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_COUNT     = 2'd1,
      ST_DONE      = 2'd2
   } seq_state_t;

   // Ceiling log2, usable in parameter and localparam expressions.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << res) < 64'(value)) res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/reset_seq_gen_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], d};
   end

   assign q = sync_q[1];

endmodule

// File: rtl/reset_seq_gen.sv
// Sequenced reset generator: qualifies PLL lock, then releases NUM_CH
// reset channels one at a time, DELAY cycles apart.
module reset_seq_gen
   import reset_seq_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DELAY       = 1000,
   parameter int CNT_W       = 16,
   parameter int LOCK_FILTER = 8,
   parameter int LOGIC_LEVEL = 0,
   localparam int STG_W      = clog2(NUM_CH + 1)
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              LOCK,
   input  logic              SOFT_RST,
   output logic [NUM_CH-1:0] RESET,
   output logic [STG_W-1:0]  STAGE,
   output logic              DONE
);

   localparam int FLT_W = clog2(LOCK_FILTER + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
   localparam logic [FLT_W-1:0] FLT_FULL = FLT_W'(LOCK_FILTER);
   localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_CH - 1);

   generate
      if (NUM_CH < 1) begin : g_bad_num_ch
         $error("reset_seq_gen: NUM_CH must be >= 1");
      end
      if (DELAY < 1) begin : g_bad_delay
         $error("reset_seq_gen: DELAY must be >= 1");
      end
      if (CNT_W < clog2(DELAY + 1)) begin : g_bad_cnt_w
         $error("reset_seq_gen: CNT_W too narrow for DELAY");
      end
      if (LOCK_FILTER < 1) begin : g_bad_filter
         $error("reset_seq_gen: LOCK_FILTER must be >= 1");
      end
   endgenerate

   logic rstn_s;
   logic lock_s;

   sync_2ff u_rst_sync (
      .clk   (CLK),
      .rst_n (RESETN),
      .d     (1'b1),
      .q     (rstn_s)
   );

   sync_2ff u_lock_sync (
      .clk   (CLK),
      .rst_n (RESETN),
      .d     (LOCK),
      .q     (lock_s)
   );

   seq_state_t        state, state_n;
   logic [FLT_W-1:0]  fcnt, fcnt_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [STG_W-1:0]  stage, stage_n;
   logic [NUM_CH-1:0] act, act_n;
   logic              done_q, done_n;
   logic              restart;

   // RESETN clears everything at once; rstn_s holds the FSM idle until the
   // synchronised release so the sequence starts on a clean edge.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state  <= ST_WAIT_LOCK;
         fcnt   <= '0;
         cnt    <= '0;
         stage  <= '0;
         act    <= '1;
         done_q <= 1'b0;
      end else if (!rstn_s) begin
         state  <= ST_WAIT_LOCK;
         fcnt   <= '0;
         cnt    <= '0;
         stage  <= '0;
         act    <= '1;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         fcnt   <= fcnt_n;
         cnt    <= cnt_n;
         stage  <= stage_n;
         act    <= act_n;
         done_q <= done_n;
      end
   end

   assign restart = ((state != ST_WAIT_LOCK) && !lock_s) || SOFT_RST;

   always_comb begin
      state_n = state;
      fcnt_n  = fcnt;
      cnt_n   = cnt;
      stage_n = stage;
      act_n   = act;
      done_n  = done_q;
      if (restart) begin
         state_n = ST_WAIT_LOCK;
         fcnt_n  = '0;
         cnt_n   = '0;
         stage_n = '0;
         act_n   = '1;
         done_n  = 1'b0;
      end else begin
         case (state)
            ST_WAIT_LOCK: begin
               if (!lock_s) begin
                  fcnt_n = '0;
               end else if (fcnt == FLT_LAST) begin
                  fcnt_n  = FLT_FULL;
                  cnt_n   = '0;
                  state_n = ST_COUNT;
               end else begin
                  fcnt_n = fcnt + 1'b1;
               end
            end
            ST_COUNT: begin
               if (cnt == CNT_LAST) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (STG_W'(i) == stage) act_n[i] = 1'b0;
                  end
                  stage_n = stage + 1'b1;
                  cnt_n   = '0;
                  if (stage == STG_LAST) begin
                     done_n  = 1'b1;
                     state_n = ST_DONE;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Polarity is a constant, so this is a plain register output.
   assign RESET = (LOGIC_LEVEL != 0) ? act : ~act;
   assign STAGE = stage;
   assign DONE  = done_q;

endmodule
